uart_bus_master: RTL and testbench
==================================

Name: uart_bus_master

Overview:
- UART-to-memory-bus debug bridge. It is the initiator counterpart of the CPU-side UART peripheral: a host or ESP8266 sends command frames on rx, and the block drives single-cycle read/write transactions on the shared memory bus.
- Read data and write acknowledgements are returned on tx.
- Sits beside the CPU on the data-memory bus; it loads memory and peeks/pokes MMIO without CPU involvement.

Parameters:
- CLKS_PER_BIT, 434, clocks per UART bit (50 MHz / 115200 baud); minimum 4.
- TIMEOUT_BITS, 20, bit-times of rx inactivity mid-frame before the partial frame is discarded.
- RD_LAT, 1, cycles from cs to valid rdata.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rx  in  1  UART serial in, 8N1, idle high
- tx  out  1  UART serial out, 8N1, idle high
- cs  out  1  bus chip select, one-cycle pulse per transaction
- we  out  1  bus write enable, valid with cs
- addr  out  32  bus address
- wdata  out  32  bus write data
- rdata  in  32  bus read data, valid RD_LAT cycles after cs
- busy  out  1  high from first command byte until the response stop bit completes

Behaviour:
- Reset (rst low, async) drives these values: tx=1, cs=0, we=0, addr=0, wdata=0, busy=0. The frame FSM goes to IDLE, the rx and tx engines go idle, and counters clear.
- A reset mid-byte or mid-frame abandons the frame with no bus cycle.
- rx path:
  - rx passes through a 2-flop synchronizer.
  - A falling edge arms start detection; the line is rechecked at CLKS_PER_BIT/2. If high there, it is a glitch and the engine returns to idle.
  - Data bits are sampled every CLKS_PER_BIT thereafter, LSB first, followed by the stop bit.
  - Stop bit = 0 is a framing error: the byte is dropped, and the frame FSM resets to IDLE without a response.
  - A good byte produces a one-cycle byte_valid.
- tx path:
  - Each byte is sent as start bit (0), 8 data bits LSB first, stop bit (1), each held exactly CLKS_PER_BIT clocks.
  - Back-to-back bytes have no extra idle gap.
- Frame FSM:
  - IDLE:
    - 0x57 'W' → ADDR, then DATA.
    - 0x52 'R' → ADDR.
    - Any other byte → RESP, sending 0x3F '?'.
  - ADDR: collect 4 bytes, MSB first, into addr.
  - DATA: collect 4 bytes, MSB first, into wdata.
  - WRITE: one cycle with cs=1, we=1, then RESP sending 0x4B 'K'.
  - READ: one cycle with cs=1, we=0. Then wait RD_LAT cycles and capture rdata on the edge ending cycle cs+RD_LAT. Then RESP sending 4 bytes, MSB first.
  - RESP: queue the bytes to the tx engine. Return to IDLE after the last stop bit.
- cs is never high more than one cycle per frame. addr and wdata hold their values after the transaction until the next frame overwrites them.
- Inter-byte timeout: in ADDR or DATA, if no byte arrives within TIMEOUT_BITS×CLKS_PER_BIT clocks of the previous stop bit, return to IDLE silently.
- Bytes received while in WRITE, READ or RESP are discarded; the host must wait for the response.
- Byte counters are 2-bit and wrap from 3 to 0 on field completion.

Test Plan:
- Directed tests use CLKS_PER_BIT=8.
- Reset: hold rst=0 for 3 cycles with rx toggling → tx=1, cs=0, busy=0 throughout. After release, an idle rx produces no activity.
- Write: send 57 E0 03 90 00 00 00 00 41 → exactly one cs=1/we=1 cycle with addr=0xE0039000 and wdata=0x00000041. tx then returns 0x4B.
- Read: bus model returns 0xDEADBEEF one cycle after cs; send 52 00 00 01 00 → one cs=1/we=0 cycle with addr=0x00000100. tx returns DE AD BE EF, MSB first; busy falls after the last stop bit.
- Errors:
  - Send 0x13 → tx returns 0x3F and there is no cs.
  - A byte with stop bit 0 inside the address field → no cs, no response, and a following valid 'R' frame completes normally.
- Timeout and glitch:
  - Send 57 E0 03, then idle for 21 bit-times, then a full 'R' frame → only the read executes.
  - A rx low pulse of 2 clocks is ignored.
- Mid-frame reset: assert rst during the 3rd data byte of a 'W' frame → no cs, outputs return to reset values, and the next frame executes correctly.

Source files
------------

// File: rtl/uart_bus_master.sv
// UART command bridge: 'W'/'R' frames on rx become single-cycle bus transactions.
// Read data or a 'K'/'?' acknowledgement is returned on tx.
`timescale 1ns/1ps
module uart_bus_master #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20,
  parameter int RD_LAT       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic        cs,
  output logic        we,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);
  localparam int RW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [RW-1:0] RD_END   = RW'(RD_LAT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WRITE, S_READ, S_RD_WAIT, S_RESP} state_t;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            byte_vld, frame_err;

  logic            tx_q, tx_act_q;
  logic [8:0]      tx_sh_q;
  logic [CW-1:0]   tx_cnt_q;
  logic [3:0]      tx_bit_q;
  logic            tx_done, tx_rdy, tx_load;
  logic [7:0]      tx_byte;

  state_t          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, resp_q, resp_d;
  logic [2:0]      left_q, left_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [RW-1:0]   rd_cnt_q, rd_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    byte_vld   = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_END) begin
        // A line that is high again at mid start bit was only a glitch.
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_END) begin
        rx_state_d = RX_IDLE;
        byte_vld   = rx_sync_q;
        frame_err  = !rx_sync_q;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A new byte may load on the final stop-bit clock, so responses go out gap-free.
  assign tx_done = tx_act_q && (tx_cnt_q == BIT_END) && (tx_bit_q == 4'd9);
  assign tx_rdy  = !tx_act_q || tx_done;
  assign tx_byte = resp_q[31:24];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_q     <= 1'b1;
      tx_act_q <= 1'b0;
      tx_sh_q  <= '1;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
    end else begin
      if (tx_act_q) begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 4'd9) begin
            tx_act_q <= 1'b0;
          end else begin
            tx_q     <= tx_sh_q[0];
            tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
            tx_bit_q <= tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_q <= tx_cnt_q + 1'b1;
        end
      end
      if (tx_load) begin
        tx_act_q <= 1'b1;
        tx_q     <= 1'b0;
        tx_sh_q  <= {1'b1, tx_byte};
        tx_cnt_q <= '0;
        tx_bit_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      left_q     <= '0;
      tmo_q      <= '0;
      rd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      left_q     <= left_d;
      tmo_q      <= tmo_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    left_d     = left_q;
    tmo_d      = tmo_q;
    rd_cnt_d   = rd_cnt_q;
    tx_load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmo_d      = '0;
        byte_cnt_d = '0;
        if (byte_vld) begin
          if (rx_sh_q == 8'h57 || rx_sh_q == 8'h52) begin
            is_wr_d = (rx_sh_q == 8'h57);
            state_d = S_ADDR;
          end else begin
            resp_d  = {8'h3F, 24'h0};
            left_d  = 3'd1;
            state_d = S_RESP;
          end
        end
      end
      S_ADDR, S_DATA: begin
        tmo_d = tmo_q + 1'b1;
        if (frame_err || tmo_q == TMO_END) begin
          state_d = S_IDLE;
        end else if (byte_vld) begin
          tmo_d      = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == S_ADDR) addr_d  = {addr_q[23:0], rx_sh_q};
          else                   wdata_d = {wdata_q[23:0], rx_sh_q};
          if (byte_cnt_q == 2'd3) begin
            if (state_q == S_DATA) state_d = S_WRITE;
            else                   state_d = is_wr_q ? S_DATA : S_READ;
          end
        end
      end
      S_WRITE: begin
        resp_d  = {8'h4B, 24'h0};
        left_d  = 3'd1;
        state_d = S_RESP;
      end
      S_READ: begin
        rd_cnt_d = '0;
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == RD_END) begin
          resp_d  = rdata;
          left_d  = 3'd4;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (left_q != 3'd0 && tx_rdy) begin
          tx_load = 1'b1;
          resp_d  = {resp_q[23:0], 8'h00};
          left_d  = left_q - 3'd1;
        end else if (left_q == 3'd0 && tx_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx    = tx_q;
  assign cs    = (state_q == S_WRITE) || (state_q == S_READ);
  assign we    = (state_q == S_WRITE);
  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: expected bus cycles and tx bytes are queued
// when a frame is sent and checked by the bus and serial monitors.
`timescale 1ns/1ps
module tb_uart_bus_master;
  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        tx, cs, we, busy;
  logic [31:0] addr, wdata;
  logic [31:0] rdata = 32'h0;
  logic        cs_seen;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];

  always #5 clk = ~clk;

  uart_bus_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .cs(cs), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic expect_bus(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus_t e;
    e.we = w; e.addr = a; e.wdata = d;
    exp_bus.push_back(e);
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(w[i*8 +: 8]);
  endtask

  // Memory model: data appears one cycle after the cs cycle, garbage otherwise.
  always @(posedge clk) begin
    cs_seen = cs;
    #1 rdata = cs_seen ? 32'hDEADBEEF : 32'h0BAD0BAD;
  end

  always @(negedge clk) begin
    if (cs === 1'b1) begin
      if (exp_bus.size() == 0) begin
        check("cs_unexpected", 32'(exp_bus.size()), 32'd1);
      end else begin
        bus_t e;
        e = exp_bus.pop_front();
        check("bus_we", 32'(we), 32'(e.we));
        check("bus_addr", addr, e.addr);
        if (e.we) check("bus_wdata", wdata, e.wdata);
      end
    end
  end

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      repeat (CPB / 2) @(negedge clk);
      check("tx_start", 32'(tx), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      check("tx_stop", 32'(tx), 32'd1);
      if (exp_tx.size() == 0) check("tx_unexpected", 32'(exp_tx.size()), 32'd1);
      else                    check("tx_byte", {24'h0, b}, {24'h0, exp_tx.pop_front()});
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_txq"}, 32'(exp_tx.size()), 32'd0);
    check({tag, "_busq"}, 32'(exp_bus.size()), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx = ~rx;
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_cs", 32'(cs), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    check("rst_addr", addr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    rx = 1'b1;
    rst = 1'b1;
    repeat (30 * CPB) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_tx", 32'(tx), 32'd1);

    expect_bus(1'b1, 32'hE0039000, 32'h00000041);
    exp_tx.push_back(8'h4B);
    send_byte(8'h57, 1'b1);
    send_word(32'hE0039000);
    send_word(32'h00000041);
    wait_done("write");
    check("write_addr_hold", addr, 32'hE0039000);
    check("write_wdata_hold", wdata, 32'h00000041);

    expect_bus(1'b0, 32'h00000100, 32'h0);
    expect_word(32'hDEADBEEF);
    send_byte(8'h52, 1'b1);
    send_word(32'h00000100);
    n = 0;
    while (exp_tx.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("read_tx_drained", 32'(exp_tx.size()), 32'd0);
    check("read_busy_in_stop", 32'(busy), 32'd1);
    check("read_tx_in_stop", 32'(tx), 32'd1);
    n = 0;
    while (busy && n < 4 * CPB) begin
      @(negedge clk);
      n++;
    end
    check("read_busy_fall", 32'(n >= 1 && n <= CPB), 32'd1);
    wait_done("read");
    check("read_addr_hold", addr, 32'h00000100);

    exp_tx.push_back(8'h3F);
    send_byte(8'h13, 1'b1);
    wait_done("badcmd");

    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("ferr_idle", 32'(busy), 32'd0);
    expect_bus(1'b0, 32'h00000200, 32'h0);
    expect_word(32'hDEADBEEF);
    send_byte(8'h52, 1'b1);
    send_word(32'h00000200);
    wait_done("ferr_read");

    send_byte(8'h57, 1'b1);
    send_byte(8'hE0, 1'b1);
    send_byte(8'h03, 1'b1);
    check("tmo_busy_before", 32'(busy), 32'd1);
    repeat (21 * CPB) @(negedge clk);
    check("tmo_idle", 32'(busy), 32'd0);
    expect_bus(1'b0, 32'h00000300, 32'h0);
    expect_word(32'hDEADBEEF);
    send_byte(8'h52, 1'b1);
    send_word(32'h00000300);
    wait_done("tmo_read");

    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_txq", 32'(exp_tx.size()), 32'd0);

    send_byte(8'h57, 1'b1);
    send_word(32'h11223344);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 1);
      repeat (CPB) @(negedge clk);
    end
    check("mfr_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    rx = 1'b1;
    #1;
    check("mfr_tx", 32'(tx), 32'd1);
    check("mfr_cs", 32'(cs), 32'd0);
    check("mfr_busy", 32'(busy), 32'd0);
    check("mfr_addr", addr, 32'h0);
    check("mfr_wdata", wdata, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    expect_bus(1'b1, 32'h00000010, 32'h12345678);
    exp_tx.push_back(8'h4B);
    send_byte(8'h57, 1'b1);
    send_word(32'h00000010);
    send_word(32'h12345678);
    wait_done("mfr_write");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
